// File: rtl/write_fifo_ctrl.sv
// write_fifo_ctrl: async FIFO write-side controller (binary/Gray write pointer, read-pointer sync, full, level).
// Optional almost-full output and AF_THRESHOLD parameter enabled by WRITE_FIFO_ALMOST_FULL_EN.
module write_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int SYNC_STAGES = 2
`ifdef WRITE_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_THRESHOLD = 6
`endif
) (
  input  logic                  w_clk_in,
  input  logic                  w_reset_in,
  input  logic                  w_request_in,
  input  logic [ADDR_WIDTH-1:0] r_ptr_gray_in,
  output logic                  w_en_out,
  output logic [ADDR_WIDTH-1:0] w_ptr_out,
  output logic [ADDR_WIDTH-1:0] w_ptr_gray_out,
  output logic                  ctrl_full_out,
  output logic [ADDR_WIDTH-1:0] w_level_out
`ifdef WRITE_FIFO_ALMOST_FULL_EN
  ,
  output logic                  ctrl_almost_full_out
`endif
);
  typedef enum logic {READY, FULL} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH-1:0] r_ptr_sync, ptr_p1, ptr_p2, ptr_d;
  function automatic logic [ADDR_WIDTH-1:0] g2b(input logic [ADDR_WIDTH-1:0] g);
    logic [ADDR_WIDTH-1:0] b;
    for (int i = 0; i < ADDR_WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  // One slot stays empty: full means the pointer sits one behind the synced read pointer.
  always_comb begin
    r_ptr_sync = g2b(sync_q[SYNC_STAGES-1]);
    ptr_p1 = w_ptr_out + ADDR_WIDTH'(1);
    ptr_p2 = w_ptr_out + ADDR_WIDTH'(2);
    w_en_out = w_request_in & (state_q == READY) & ~w_reset_in;
    ptr_d = w_en_out ? ptr_p1 : w_ptr_out;
    state_d = (state_q == READY) ? ((w_en_out && ptr_p2 == r_ptr_sync) ? FULL : READY)
                                 : ((ptr_p1 != r_ptr_sync) ? READY : FULL);
    ctrl_full_out = (state_q == FULL) & ~w_reset_in;
    w_level_out = w_reset_in ? '0 : w_ptr_out - r_ptr_sync;
  end
  always_ff @(posedge w_clk_in) begin
    if (w_reset_in) begin
      state_q <= READY;
      w_ptr_out <= '0;
      w_ptr_gray_out <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q <= state_d;
      w_ptr_out <= ptr_d;
      w_ptr_gray_out <= ptr_d ^ (ptr_d >> 1);
      sync_q[0] <= r_ptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
`ifdef WRITE_FIFO_ALMOST_FULL_EN
  // Look ahead one stage in the synchronizer so the flag matches next cycle's level.
  logic af_q;
  logic [ADDR_WIDTH-1:0] lvl_d;
  assign lvl_d = ptr_d - g2b(sync_q[SYNC_STAGES-2]);
  always_ff @(posedge w_clk_in) af_q <= w_reset_in ? 1'b0 : (32'(lvl_d) >= AF_THRESHOLD);
  assign ctrl_almost_full_out = af_q & ~w_reset_in;
`endif
endmodule

// File: tb/tb_write_fifo_ctrl.sv
// tb_write_fifo_ctrl: directed + random checks of write_fifo_ctrl against a count-based FIFO model.
module tb_write_fifo_ctrl;
  localparam int AW = 3, SS = 2, AF = 6, D = 1 << AW;
  logic clk = 0, rst = 1, req = 0;
  logic [AW-1:0] r_gray = '0;
  logic en, full;
  logic [AW-1:0] ptr, gray, level;
`ifdef WRITE_FIFO_ALMOST_FULL_EN
  logic af;
`endif
  int n_cmp = 0, n_bad = 0;
  int wc = 0, rc = 0, rs = 0;
  bit full_m = 0;
  int hist[$];
  always #5 clk = ~clk;
  write_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .SYNC_STAGES(SS)
`ifdef WRITE_FIFO_ALMOST_FULL_EN
    ,
    .AF_THRESHOLD(AF)
`endif
  ) dut (
    .w_clk_in(clk),
    .w_reset_in(rst),
    .w_request_in(req),
    .r_ptr_gray_in(r_gray),
    .w_en_out(en),
    .w_ptr_out(ptr),
    .w_ptr_gray_out(gray),
    .ctrl_full_out(full),
    .w_level_out(level)
`ifdef WRITE_FIFO_ALMOST_FULL_EN
    ,
    .ctrl_almost_full_out(af)
`endif
  );
  function automatic logic [AW-1:0] gray_of(input int v);
    logic [AW-1:0] b;
    b = AW'(v % D);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // wc/rc are absolute write/read counts; rs is the read count visible after synchronization.
  task automatic cyc(input bit r, input bit q);
    int lvl, rs_prev;
    bit e;
    @(negedge clk);
    rst = r;
    req = q;
    r_gray = gray_of(rc);
    #1;
    e = !r && q && !full_m;
    lvl = r ? 0 : (wc - rs) % D;
    chk("w_en", 32'(en), 32'(e));
    chk("w_ptr", 32'(ptr), 32'(wc % D));
    chk("w_gray", 32'(gray), 32'(gray_of(wc)));
    chk("full", 32'(full), 32'(!r && full_m));
    chk("level", 32'(level), 32'(lvl));
`ifdef WRITE_FIFO_ALMOST_FULL_EN
    chk("almost_full", 32'(af), 32'(!r && lvl >= AF));
`endif
    @(posedge clk);
    if (r) begin
      wc = 0;
      rs = 0;
      full_m = 0;
      hist.delete();
    end else begin
      rs_prev = rs;
      if (e) wc++;
      hist.push_back(rc);
      if (hist.size() > SS) void'(hist.pop_front());
      rs = (hist.size() == SS) ? hist[0] : 0;
      full_m = ((wc + 1) % D) == (rs_prev % D);
    end
  endtask
  initial begin
    rc = 0;
    repeat (3) cyc(1, 1);
    repeat (7) cyc(0, 1);
    #1;
    chk("dir_full7", 32'(full), 32'd1);
    chk("dir_ptr7", 32'(ptr), 32'd7);
    chk("dir_lvl7", 32'(level), 32'd7);
    cyc(0, 1);
    #1;
    chk("dir_ptr_held", 32'(ptr), 32'd7);
    rc = 1;
    repeat (2) cyc(0, 0);
    #1;
    chk("dir_full_hold", 32'(full), 32'd1);
    cyc(0, 0);
    #1;
    chk("dir_full_fall", 32'(full), 32'd0);
    cyc(0, 1);
    #1;
    chk("dir_wrap", 32'(ptr), 32'd0);
    chk("dir_wrap_gray", 32'(gray), 32'd0);
    rc = 0;
    cyc(1, 0);
    #1;
    chk("dir_rst_ptr", 32'(ptr), 32'd0);
    chk("dir_rst_lvl", 32'(level), 32'd0);
    chk("dir_rst_full", 32'(full), 32'd0);
    cyc(0, 1);
    repeat (600) begin
      if ($urandom_range(0, 149) == 0) begin
        rc = 0;
        cyc(1, 1'($urandom_range(0, 1)));
      end else begin
        if (rc < wc && $urandom_range(0, 2) == 0) rc++;
        cyc(0, $urandom_range(0, 3) != 0);
      end
    end
    repeat (40) begin
      if (rc < wc && $urandom_range(0, 1) == 0) rc++;
      cyc(0, $urandom_range(0, 4) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
